bsg_manycore_ruche_edge_link_arbiter: RTL

- Sits at the east edge of a ruche compute subarray, one instance per tile row.
- Shares one off-array physical link between the local mesh E channel and the ruche_factor_X_p ruche E channels.
- TX side: round-robin arbitration among the channels into a registered output that carries a channel id.
- RX side: a registered demux steers returning packets back to the channel named by their id.

---
 rtl/bsg_manycore_ruche_edge_link_arbiter_pkg.sv | 16 +
 rtl/bsg_manycore_ruche_edge_link_arbiter_if.sv | 41 ++++
 rtl/bsg_manycore_ruche_edge_rr_arb.sv | 33 +++
 rtl/bsg_manycore_ruche_edge_link_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/bsg_manycore_ruche_edge_link_arbiter_pkg.sv
// Shared types and constants for the ruche east-edge link arbiter.
// The packet struct is width-parameterised, so it is declared through a macro inside each user.
`ifndef BSG_MANYCORE_RUCHE_EDGE_PKT_MACRO
`define BSG_MANYCORE_RUCHE_EDGE_PKT_MACRO
`define BSG_DECLARE_MANYCORE_RUCHE_EDGE_PKT_S(width_mp, id_width_mp) typedef struct packed { logic [(id_width_mp)-1:0] id; logic [(width_mp)-1:0] payload; } bsg_manycore_ruche_edge_pkt_s
`endif

package bsg_manycore_ruche_edge_link_arbiter_pkg;

  localparam int e_edge_ch_mesh = 0;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_manycore_ruche_edge_link_arbiter_if.sv
// Channel-side and link-side signals of the edge arbiter, grouped for port binding.
// Every handshake is valid/ready_and: a beat transfers in any cycle where valid and ready are both high.
interface bsg_manycore_ruche_edge_link_arbiter_if
  import bsg_manycore_ruche_edge_link_arbiter_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int ruche_factor_X_p = 3
);
  localparam int num_ch_lp   = ruche_factor_X_p + 1;
  localparam int id_width_lp = safe_clog2(num_ch_lp);

  logic [num_ch_lp-1:0]           ch_v_i;
  logic [num_ch_lp*width_p-1:0]   ch_data_i;
  logic [num_ch_lp-1:0]           ch_ready_o;
  logic                           link_v_o;
  logic [id_width_lp+width_p-1:0] link_data_o;
  logic                           link_ready_i;

  logic                           link_v_i;
  logic [id_width_lp+width_p-1:0] link_data_i;
  logic                           link_ready_o;
  logic [num_ch_lp-1:0]           ch_v_o;
  logic [width_p-1:0]             ch_data_o;
  logic [num_ch_lp-1:0]           ch_ready_i;

  logic                           bad_id_o;
  // Debug view of the round-robin pointer.
  logic [id_width_lp-1:0]         rr_ptr_o;

  modport slave (
    input  ch_v_i, ch_data_i, link_ready_i, link_v_i, link_data_i, ch_ready_i,
    output ch_ready_o, link_v_o, link_data_o, link_ready_o, ch_v_o, ch_data_o,
           bad_id_o, rr_ptr_o
  );

  modport master (
    output ch_v_i, ch_data_i, link_ready_i, link_v_i, link_data_i, ch_ready_i,
    input  ch_ready_o, link_v_o, link_data_o, link_ready_o, ch_v_o, ch_data_o,
           bad_id_o, rr_ptr_o
  );
endinterface

// File: rtl/bsg_manycore_ruche_edge_rr_arb.sv
// Combinational round-robin picker: first requester at or above rr_ptr_i, wrapping.
// The pointer itself is owned and advanced by the parent.
module bsg_manycore_ruche_edge_rr_arb #(
  parameter int num_ch_p   = 4,
  parameter int id_width_p = 2
) (
  input  logic [num_ch_p-1:0]   req_i,
  input  logic [id_width_p-1:0] rr_ptr_i,
  output logic [num_ch_p-1:0]   gnt_oh_o,
  output logic [id_width_p-1:0] gnt_id_o,
  output logic                  gnt_v_o
);
  int                  idx;
  logic [id_width_p-1:0] idx_w;

  always_comb begin
    gnt_oh_o = '0;
    gnt_id_o = '0;
    gnt_v_o  = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int k = 0; k < num_ch_p; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= num_ch_p) idx = idx - num_ch_p;
      idx_w = id_width_p'(idx);
      if (!gnt_v_o && req_i[idx_w]) begin
        gnt_v_o         = 1'b1;
        gnt_id_o        = idx_w;
        gnt_oh_o[idx_w] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bsg_manycore_ruche_edge_link_arbiter.sv
// East-edge link sharing for one tile row: round-robin TX mux into a registered link
// output tagged with channel id, and a registered RX demux steered by that id.
module bsg_manycore_ruche_edge_link_arbiter
  import bsg_manycore_ruche_edge_link_arbiter_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int ruche_factor_X_p = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_manycore_ruche_edge_link_arbiter_if.slave link
);
  localparam int num_ch_lp   = ruche_factor_X_p + 1;
  localparam int id_width_lp = safe_clog2(num_ch_lp);

  `BSG_DECLARE_MANYCORE_RUCHE_EDGE_PKT_S(width_p, id_width_lp);

  // ---------------- TX ----------------
  logic [num_ch_lp-1:0]   gnt_oh;
  logic [id_width_lp-1:0] gnt_id;
  logic                   gnt_v;
  logic [id_width_lp-1:0] rr_ptr, rr_next;
  logic [width_p-1:0]     gnt_data;
  logic                   tx_full, can_load, tx_load;
  bsg_manycore_ruche_edge_pkt_s tx_pkt;

  bsg_manycore_ruche_edge_rr_arb #(
    .num_ch_p  (num_ch_lp),
    .id_width_p(id_width_lp)
  ) arb (
    .req_i   (link.ch_v_i),
    .rr_ptr_i(rr_ptr),
    .gnt_oh_o(gnt_oh),
    .gnt_id_o(gnt_id),
    .gnt_v_o (gnt_v)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < num_ch_lp; i++)
      if (gnt_oh[i]) gnt_data = link.ch_data_i[i*width_p +: width_p];
  end

  // Draining and reloading in the same cycle keeps one packet per cycle on the link.
  assign can_load = ~tx_full | link.link_ready_i;
  assign tx_load  = can_load & gnt_v;
  assign rr_next  = (gnt_id == id_width_lp'(num_ch_lp-1)) ? id_width_lp'(e_edge_ch_mesh)
                                                           : gnt_id + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_full <= 1'b0;
      rr_ptr  <= id_width_lp'(e_edge_ch_mesh);
    end else if (tx_load) begin
      tx_full <= 1'b1;
      rr_ptr  <= rr_next;
    end else if (link.link_ready_i) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_load) tx_pkt <= '{id: gnt_id, payload: gnt_data};
  end

  assign link.ch_ready_o  = can_load ? gnt_oh : '0;
  assign link.link_v_o    = tx_full;
  assign link.link_data_o = tx_pkt;
  assign link.rr_ptr_o    = rr_ptr;

  // ---------------- RX ----------------
  bsg_manycore_ruche_edge_pkt_s in_pkt, rx_pkt;
  logic                 rx_full, bad_id;
  logic                 in_legal, rx_legal, rx_sel_ready, rx_ready, rx_accept, rx_deq;
  logic [num_ch_lp-1:0] ch_v;

  assign in_pkt   = link.link_data_i;
  assign in_legal = {1'b0, in_pkt.id} < (id_width_lp+1)'(num_ch_lp);
  assign rx_legal = {1'b0, rx_pkt.id} < (id_width_lp+1)'(num_ch_lp);

  assign rx_sel_ready = rx_legal & link.ch_ready_i[rx_pkt.id];
  assign rx_ready     = ~rx_full | rx_sel_ready;
  assign rx_accept    = link.link_v_i & rx_ready;
  assign rx_deq       = rx_full & rx_sel_ready;

  // Illegal ids are consumed off the link but never occupy the register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_full <= 1'b0;
      bad_id  <= 1'b0;
    end else begin
      if (rx_accept & in_legal) rx_full <= 1'b1;
      else if (rx_deq)          rx_full <= 1'b0;
      if (rx_accept & ~in_legal) bad_id <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_accept & in_legal) rx_pkt <= in_pkt;
  end

  always_comb begin
    ch_v = '0;
    for (int i = 0; i < num_ch_lp; i++)
      ch_v[i] = rx_full & (rx_pkt.id == id_width_lp'(i));
  end

  assign link.link_ready_o = rx_ready;
  assign link.ch_v_o       = ch_v;
  assign link.ch_data_o    = rx_pkt.payload;
  assign link.bad_id_o     = bad_id;
endmodule
